// File: rtl/div_unit_pkg.sv
// Shared processor definitions for the iterative divider: op encodings,
// FSM state encoding and the 32-bit boundary constants.
package div_unit_pkg;

    localparam int unsigned WORD_W = 32;

    // funct3[1:0] of the RV32M divide group
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam logic [WORD_W-1:0] INT_MIN  = 32'h8000_0000;
    localparam logic [WORD_W-1:0] ALL_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_unit_sub.sv
// DSP-based 32-bit subtractor used for the restoring-division trial step.
// Ports:
//   a       minuend
//   b       subtrahend
//   diff_c  a - b (mod 2^W), combinational
module div_unit_sub #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff_c
);

    assign diff_c = a - b;

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), restoring division with one
// quotient bit per cycle. Stalls the pipeline through busy.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               accept a new operation (ignored while busy)
//   op                  00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend, divisor   rs1 / rs2, captured when start is accepted
//   busy                operation in flight (PREP, ITER, FIX)
//   done                one-cycle pulse when result is valid
//   result              quotient or remainder, held until next accepted start
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CNT_W = $clog2(XLEN);

    state_e            state, state_next;
    op_e               op_q, op_next;
    logic [XLEN-1:0]   dvd_q, dvd_next;
    logic [XLEN-1:0]   dvs_q, dvs_next;
    logic [XLEN-1:0]   a_q, a_next;
    logic [XLEN-1:0]   b_q, b_next;
    logic [XLEN-1:0]   r_q, r_next;
    logic [XLEN-1:0]   q_q, q_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              neg_q, neg_q_next;
    logic              neg_r, neg_r_next;
    logic [XLEN-1:0]   result_next;
    logic              busy_next, done_next;

    logic [XLEN-1:0]   t_c;
    logic [XLEN-1:0]   d_c;
    logic              borrow_c;
    logic              take_c;
    logic              is_signed_c;
    logic              is_rem_c;

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] x);
        return ~x + XLEN'(1);
    endfunction

    function automatic logic [XLEN-1:0] abs_if(input logic en, input logic [XLEN-1:0] x);
        return (en && x[XLEN-1]) ? negate(x) : x;
    endfunction

    // Trial operand: remainder shifted left with the next dividend bit
    assign t_c = {r_q[XLEN-2:0], a_q[cnt]};

    div_unit_sub #(.W(XLEN)) u_sub (
        .a      (t_c),
        .b      (b_q),
        .diff_c (d_c)
    );

    // Unsigned borrow of T - B recovered from the sign bits and difference
    assign borrow_c = (~t_c[XLEN-1] & b_q[XLEN-1])
                    | (~(t_c[XLEN-1] ^ b_q[XLEN-1]) & d_c[XLEN-1]);
    // Shifted-out R[31] means the true 33-bit T exceeds any 32-bit B
    assign take_c      = r_q[XLEN-1] | ~borrow_c;
    assign is_signed_c = ~op_q[0];
    assign is_rem_c    = op_q[1];

    // Next-state and datapath
    always_comb begin
        state_next  = state;
        op_next     = op_q;
        dvd_next    = dvd_q;
        dvs_next    = dvs_q;
        a_next      = a_q;
        b_next      = b_q;
        r_next      = r_q;
        q_next      = q_q;
        cnt_next    = cnt;
        neg_q_next  = neg_q;
        neg_r_next  = neg_r;
        result_next = result;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    op_next    = op_e'(op);
                    dvd_next   = dividend;
                    dvs_next   = divisor;
                    state_next = ST_PREP;
                end else begin
                    state_next = ST_IDLE;
                end
            end

            ST_PREP: begin
                a_next     = abs_if(is_signed_c, dvd_q);
                b_next     = abs_if(is_signed_c, dvs_q);
                neg_q_next = is_signed_c & (dvd_q[XLEN-1] ^ dvs_q[XLEN-1]);
                neg_r_next = is_signed_c & dvd_q[XLEN-1];
                r_next     = '0;
                q_next     = '0;
                cnt_next   = CNT_W'(XLEN - 1);
                if (dvs_q == '0) begin
                    result_next = is_rem_c ? dvd_q : ALL_ONES;
                    state_next  = ST_DONE;
                end else if (is_signed_c && dvd_q == INT_MIN && dvs_q == ALL_ONES) begin
                    result_next = is_rem_c ? '0 : INT_MIN;
                    state_next  = ST_DONE;
                end else begin
                    state_next  = ST_ITER;
                end
            end

            ST_ITER: begin
                r_next      = take_c ? d_c : t_c;
                q_next[cnt] = take_c;
                cnt_next    = cnt - CNT_W'(1);
                if (cnt == '0) begin
                    state_next = ST_FIX;
                end
            end

            ST_FIX: begin
                if (is_rem_c) begin
                    result_next = neg_r ? negate(r_q) : r_q;
                end else begin
                    result_next = neg_q ? negate(q_q) : q_q;
                end
                state_next = ST_DONE;
            end

            default: state_next = ST_IDLE;
        endcase

        busy_next = (state_next == ST_PREP) || (state_next == ST_ITER) || (state_next == ST_FIX);
        done_next = (state_next == ST_DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            op_q   <= OP_DIV;
            dvd_q  <= '0;
            dvs_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            r_q    <= '0;
            q_q    <= '0;
            cnt    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_next;
            op_q   <= op_next;
            dvd_q  <= dvd_next;
            dvs_q  <= dvs_next;
            a_q    <= a_next;
            b_q    <= b_next;
            r_q    <= r_next;
            q_q    <= q_next;
            cnt    <= cnt_next;
            neg_q  <= neg_q_next;
            neg_r  <= neg_r_next;
            result <= result_next;
            busy   <= busy_next;
            done   <= done_next;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed, table-driven bench for div_unit plus handshake/reset sequences.
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_cmp;
    int n_err;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[$];

    div_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    // Advance negedges until done is seen or the budget runs out
    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Issue one op, check latency, busy profile and result
    task automatic run_op(input vec_t v);
        int cyc;
        bit busy_ok;
        @(negedge clk);
        op = v.op; dividend = v.x; divisor = v.y; start = 1'b1;
        @(negedge clk);                       // cycle 1
        start = 1'b0;
        dividend = $urandom; divisor = $urandom;   // must be ignored
        op = 2'($urandom);
        cyc = 1;
        busy_ok = 1'b1;
        while (!done && cyc < 100) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        if (busy) busy_ok = 1'b0;
        check({v.name, " latency"}, 32'(cyc), 32'(v.lat));
        check({v.name, " busy"}, {31'd0, busy_ok}, 32'd1);
        check({v.name, " result"}, result, v.exp);
    endtask

    initial begin
        int n;
        int extra;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1; start = 1'b0; op = 2'b00; dividend = '0; divisor = '0;

        vecs.push_back('{2'b01, 32'd100,        32'd7,          32'd14,         35, "divu_100_7"});
        vecs.push_back('{2'b11, 32'd100,        32'd7,          32'd2,          35, "remu_100_7"});
        vecs.push_back('{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  35, "div_m7_2"});
        vecs.push_back('{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  35, "rem_m7_2"});
        vecs.push_back('{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          35, "rem_7_m2"});
        vecs.push_back('{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  35, "div_7_m2"});
        vecs.push_back('{2'b00, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         35, "div_m100_m7"});
        vecs.push_back('{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  35, "divu_max_1"});
        vecs.push_back('{2'b01, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          35, "divu_wide"});
        vecs.push_back('{2'b11, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  35, "remu_wide"});
        vecs.push_back('{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          35, "divu_min_ones"});
        vecs.push_back('{2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  35, "remu_min_ones"});
        vecs.push_back('{2'b00, 32'h8000_0000,  32'd2,          32'hC000_0000,  35, "div_min_2"});
        vecs.push_back('{2'b10, 32'h8000_0000,  32'd3,          32'hFFFF_FFFE,  35, "rem_min_3"});
        vecs.push_back('{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  2,  "div_by0"});
        vecs.push_back('{2'b10, 32'd5,          32'd0,          32'd5,          2,  "rem_by0"});
        vecs.push_back('{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  2,  "divu_by0"});
        vecs.push_back('{2'b11, 32'd5,          32'd0,          32'd5,          2,  "remu_by0"});
        vecs.push_back('{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  2,  "div_ovf"});
        vecs.push_back('{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          2,  "rem_ovf"});

        repeat (3) @(negedge clk);
        check("reset busy",   {31'd0, busy}, 32'd0);
        check("reset done",   {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) run_op(vecs[i]);

        // Second start while busy is ignored and not queued
        @(negedge clk);
        op = 2'b01; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);            // cycle 4
        op = 2'b00; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        @(negedge clk);                       // cycle 5
        start = 1'b0;
        wait_done(100, n);
        check("busy_start latency", 32'(5 + n), 32'd35);
        check("busy_start result", result, 32'd14);
        @(negedge clk);
        check("done pulse width", {31'd0, done}, 32'd0);
        wait_done(40, extra);
        check("busy_start not queued", {31'd0, done}, 32'd0);

        // Start in the DONE cycle is accepted back-to-back
        @(negedge clk);
        op = 2'b01; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(100, n);
        check("b2b first result", result, 32'd14);
        op = 2'b11; dividend = 32'd100; divisor = 32'd7; start = 1'b1;   // during DONE
        @(negedge clk);                       // cycle 1 of the second op
        start = 1'b0;
        check("b2b prep busy", {31'd0, busy}, 32'd1);
        wait_done(100, n);
        check("b2b second latency", 32'(1 + n), 32'd35);
        check("b2b second result", result, 32'd2);

        // Reset during iteration 10 (cycle 11)
        @(negedge clk);
        op = 2'b01; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);           // cycle 11
        check("pre-reset busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("midreset busy",   {31'd0, busy}, 32'd0);
        check("midreset done",   {31'd0, done}, 32'd0);
        check("midreset result", result, 32'd0);
        reset = 1'b0;
        wait_done(40, extra);
        check("midreset no done", {31'd0, done}, 32'd0);

        // Unit still works after mid-operation reset
        run_op(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions. It runs restoring division one quotient bit per cycle. Each step's trial subtraction is done by an instance of the processor's DSP-based 32-bit `sub` block, so this unit both feeds that subtractor and consumes its difference. It sits beside the ALU in the execute stage and stalls the pipeline through its `busy` output.

## Interface
Parameters:
- XLEN, 32, operand and result width; only 32 is supported.

Ports:
- clk  in  1  processor clock. One clock; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high reset.
- start  in  1  accept a new operation; sampled only when not busy.
- op  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend  in  32  rs1 value; captured when start is accepted.
- divisor  in  32  rs2 value; captured when start is accepted.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when result becomes valid.
- result  out  32  quotient or remainder; held until the next accepted start.

## Operation
- FSM states are IDLE, PREP, ITER, FIX and DONE.
- busy = (state is PREP, ITER or FIX).
- done = (state is DONE).
- IDLE/DONE + start: latch op, dividend and divisor; go to PREP.
- DONE without start: return to IDLE.
- PREP:
  - Signed ops (DIV, REM) take the absolute values of both operands into registers A (dividend) and B (divisor).
  - Store neg_q = sign(dividend) XOR sign(divisor), and neg_r = sign(dividend).
  - Clear the remainder R and the quotient Q; set cnt = 31.
- Special cases, detected in PREP; these skip ITER/FIX, load result directly and go to DONE:
  - divisor == 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the original dividend.
  - DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
- ITER, each cycle:
  - Form T = {R[30:0], A[cnt]}, with carry-out bit c = R[31].
  - The subtractor computes D = T − B.
  - Borrow = (~T[31] & B[31]) | (~(T[31]^B[31]) & D[31]).
  - Take the subtraction if c | ~borrow: R ← D and Q[cnt] ← 1. Otherwise R ← T and Q[cnt] ← 0.
  - cnt decrements each cycle; leave ITER after the cnt == 0 step.
- FIX:
  - DIV/DIVU: result = neg_q ? −Q : Q.
  - REM/REMU: result = neg_r ? −R : R.
  - Negation is two's complement, mod 2^32.
  - Then go to DONE.
- Input changes while busy are ignored. start while busy is ignored and is not queued.

## Timing
- Reset values: state IDLE, busy 0, done 0, result 0x00000000, cnt 0, R/Q/A/B 0.
- Reset mid-operation: the next cycle shows IDLE with busy 0; no done pulse is emitted and result is cleared.
- Normal latency, with start sampled at edge 0:
  - PREP in cycle 1.
  - ITER in cycles 2–33.
  - FIX in cycle 34.
  - done high and result valid in cycle 35.
  - busy is high in cycles 1–34.
- Special-case latency: PREP in cycle 1; done in cycle 2.
- Back-to-back operation: start asserted during the DONE cycle is accepted, so the next PREP follows immediately.
- The subtractor path is combinational within one cycle. R, Q and cnt update on the ITER clock edge.

## Structure
- Shared processor package holds:
  - the op encodings (DIV, DIVU, REM, REMU);
  - the FSM state encoding (3 bits);
  - the constants INT_MIN (0x80000000) and ALL_ONES (0xFFFFFFFF).
- One sub-module: the existing DSP `sub` block, instanced once for the ITER trial subtraction.
- Absolute value, negation, borrow logic and FSM are implemented inline.

## Test plan
- DIVU 100 / 7, start at cycle 0: busy high in cycles 1–34; done in cycle 35 with result 14. Then REMU 100 / 7 → 2.
- DIV −7 / 2 → 0xFFFFFFFD (−3). REM −7 / 2 → 0xFFFFFFFF (−1). REM 7 / −2 → 1.
- Wide-remainder path: DIVU 0xFFFFFFFF / 1 → 0xFFFFFFFF. DIVU 0xFFFFFFFF / 0x80000001 → 1. REMU of the latter → 0x7FFFFFFE.
- Divide by zero, 5 / 0: DIV → 0xFFFFFFFF and REM → 5, each with done in cycle 2. Overflow: DIV 0x80000000 / −1 → 0x80000000; REM of the same → 0.
- Reset asserted during iteration 10: busy 0 next cycle; no done pulse; result 0.
- Handshake:
  - A second start while busy, with different operands, is ignored; the first result (DIVU 100 / 7 → 14) is unaffected.
  - A start in the DONE cycle is accepted; the new done follows 35 cycles later.
